// File: rtl/mips_mem_arb_pkg.sv
// Shared encodings for the MIPS I/D-cache memory arbiter: FSM states, owner and command codes.
package mips_mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OWN_I  = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/mips_mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MIPS_MEM_ARB_RR_EN: round-robin on a tie; otherwise the D-side always wins.
module mips_mem_arb_pick
  import mips_mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic grant_d
);

`ifdef MIPS_MEM_ARB_RR_EN
  // A tie goes to whichever side was not served last.
  assign grant_d = d_req && (!i_req || (last_owner == OWN_I));
`else
  logic w_unused_last_owner;
  assign w_unused_last_owner = last_owner;
  assign grant_d = d_req;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one off-chip memory port between the I-cache and D-cache miss engines.
// Build option MIPS_MEM_ARB_RR_EN selects round-robin tie-breaking (see mips_mem_arb_pick).
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [LINE_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_owner
);

  state_t              r_state;
  logic                r_owner;
  logic                r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_ic_ready;
  logic                r_dc_ready;

  logic                w_i_req;
  logic                w_d_req;
  logic                w_grant_d;

  assign w_i_req = ic_mem_read;
  assign w_d_req = dc_mem_read | dc_mem_write;

  // The owner register doubles as last_owner: at every IDLE it holds the side served last.
  mips_mem_arb_pick u_pick (
    .i_req      (w_i_req),
    .d_req      (w_d_req),
    .last_owner (r_owner),
    .grant_d    (w_grant_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_I;
      r_cmd       <= CMD_RD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ic_ready  <= 1'b0;
      r_dc_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_i_req || w_d_req) begin
            r_owner <= w_grant_d;
            r_state <= S_BUSY;
            if (w_grant_d) begin
              // A simultaneous read is dropped in favour of the write-back.
              r_cmd       <= dc_mem_write ? CMD_WR : CMD_RD;
              r_addr      <= dc_mem_addr;
              r_wdata     <= dc_mem_write ? dc_mem_wdata : '0;
              r_mem_read  <= ~dc_mem_write;
              r_mem_write <= dc_mem_write;
            end else begin
              r_cmd       <= CMD_RD;
              r_addr      <= ic_mem_addr;
              r_wdata     <= '0;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            r_rdata     <= (r_cmd == CMD_RD) ? mem_rdata : '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ic_ready  <= (r_owner == OWN_I);
            r_dc_ready  <= (r_owner == OWN_D);
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign arb_owner    = r_owner;
  assign ic_mem_ready = r_ic_ready;
  assign dc_mem_ready = r_dc_ready;
  assign ic_mem_rdata = r_ic_ready ? r_rdata : '0;
  assign dc_mem_rdata = r_dc_ready ? r_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed plus randomized bench for mips_mem_arbiter against a transaction-level model.
module tb_mips_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ic_mem_read = 1'b0;
  logic [ADDR_W-1:0] ic_mem_addr = '0;
  logic [LINE_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;
  logic              dc_mem_read = 1'b0;
  logic              dc_mem_write = 1'b0;
  logic [ADDR_W-1:0] dc_mem_addr = '0;
  logic [LINE_W-1:0] dc_mem_wdata = '0;
  logic [LINE_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              arb_owner;

  int n_checks = 0;
  int n_err    = 0;
  bit model_last_d = 1'b0;
  logic [LINE_W-1:0] exp_q[$];

  mips_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
    .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
    .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_owner(arb_owner)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_ic_ready"}, ic_mem_ready, 1'b0);
    chk({tag, "_dc_ready"}, dc_mem_ready, 1'b0);
    chk({tag, "_ic_rdata"}, ic_mem_rdata, '0);
    chk({tag, "_dc_rdata"}, dc_mem_rdata, '0);
  endtask

  // One whole transaction, starting at a falling edge while the arbiter is idle
  // and the requests are already driven. Memory answers after lat cycles.
  task automatic serve(input int lat, input logic [LINE_W-1:0] data,
                       input bit toggle, input bit drop_busy);
    bit win_d, wr, d_req;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ew, er;
    d_req = dc_mem_read | dc_mem_write;
`ifdef MIPS_MEM_ARB_RR_EN
    win_d = d_req && (!ic_mem_read || !model_last_d);
`else
    win_d = d_req;
`endif
    wr = win_d && dc_mem_write;
    ea = win_d ? dc_mem_addr : ic_mem_addr;
    ew = dc_mem_wdata;
    exp_q.push_back(wr ? '0 : data);

    step();
    chk("grant_mem_read", mem_read, !wr);
    chk("grant_mem_write", mem_write, wr);
    chk("grant_mem_addr", mem_addr, ea);
    chk("grant_owner", arb_owner, win_d);
    if (wr) chk("grant_mem_wdata", mem_wdata, ew);

    for (int i = 1; i < lat; i++) begin
      if (toggle) begin
        ic_mem_addr  = ADDR_W'($urandom);
        dc_mem_addr  = ADDR_W'($urandom);
        dc_mem_wdata = rand_line();
      end
      if (drop_busy && i == 1) begin
        if (win_d) begin dc_mem_read = 1'b0; dc_mem_write = 1'b0; end
        else ic_mem_read = 1'b0;
      end
      step();
      chk("busy_mem_read", mem_read, !wr);
      chk("busy_mem_write", mem_write, wr);
      chk("busy_mem_addr", mem_addr, ea);
      if (wr) chk("busy_mem_wdata", mem_wdata, ew);
      chk("busy_no_ready", ic_mem_ready | dc_mem_ready, 1'b0);
    end

    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
    mem_rdata = rand_line();
    er = exp_q.pop_front();
    chk("done_ic_ready", ic_mem_ready, !win_d);
    chk("done_dc_ready", dc_mem_ready, win_d);
    chk("done_ic_rdata", ic_mem_rdata, win_d ? '0 : er);
    chk("done_dc_rdata", dc_mem_rdata, win_d ? er : '0);
    chk("done_strobes", mem_read | mem_write, 1'b0);
    if (win_d) begin dc_mem_read = 1'b0; dc_mem_write = 1'b0; end
    else ic_mem_read = 1'b0;
    model_last_d = win_d;

    step();
    chk("after_ready_low", ic_mem_ready | dc_mem_ready, 1'b0);
  endtask

  initial begin
    int pat;
    logic [LINE_W-1:0] line_a5;
    logic [LINE_W-1:0] line_db;

    // Reset state
    step();
    step();
    chk_quiet("reset");
    chk("reset_owner", arb_owner, 1'b0);
    chk("reset_mem_addr", mem_addr, '0);
    chk("reset_mem_wdata", mem_wdata, '0);
    rst_n = 1'b1;
    step();

    // I-only fill, memory answers after 3 cycles
    line_a5 = {16{8'hA5}};
    ic_mem_addr = 28'h0000010;
    ic_mem_read = 1'b1;
    serve(3, line_a5, 1'b0, 1'b0);

    // Tie: both reads raised together; the other side follows right after
    ic_mem_addr = 28'h0000100;
    dc_mem_addr = 28'h0000200;
    ic_mem_read = 1'b1;
    dc_mem_read = 1'b1;
    serve(2, rand_line(), 1'b0, 1'b0);
    serve(2, rand_line(), 1'b0, 1'b0);

    // Three tie rounds in a row
    for (int r = 0; r < 3; r++) begin
      ic_mem_addr = ADDR_W'($urandom);
      dc_mem_addr = ADDR_W'($urandom);
      ic_mem_read = 1'b1;
      dc_mem_read = 1'b1;
      serve(1, rand_line(), 1'b0, 1'b0);
      serve(1, rand_line(), 1'b0, 1'b0);
    end

    // Write-back with wdata/addr toggled while busy
    line_db = {4{32'hDEAD_BEEF}};
    dc_mem_addr  = 28'h0ABCDE0;
    dc_mem_wdata = line_db;
    dc_mem_write = 1'b1;
    serve(4, rand_line(), 1'b1, 1'b0);

    // Read and write-back together: the write is performed
    dc_mem_addr  = 28'h0123450;
    dc_mem_wdata = rand_line();
    dc_mem_read  = 1'b1;
    dc_mem_write = 1'b1;
    serve(2, rand_line(), 1'b0, 1'b0);

    // Stray mem_ready while idle
    mem_ready = 1'b1;
    mem_rdata = rand_line();
    step();
    mem_ready = 1'b0;
    step();
    chk_quiet("stray_idle");

    // Requester drops while busy: transaction still completes
    ic_mem_addr = 28'h0FEDCB0;
    ic_mem_read = 1'b1;
    serve(3, rand_line(), 1'b0, 1'b1);

    // Reset during BUSY, then a late mem_ready
    dc_mem_addr = 28'h0777770;
    dc_mem_read = 1'b1;
    step();
    chk("pre_reset_busy", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_quiet("mid_reset");
    chk("mid_reset_owner", arb_owner, 1'b0);
    dc_mem_read = 1'b0;
    model_last_d = 1'b0;
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = rand_line();
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("post_reset");
      step();
    end

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      pat = $urandom_range(0, 5);
      ic_mem_addr  = ADDR_W'($urandom);
      dc_mem_addr  = ADDR_W'($urandom);
      dc_mem_wdata = rand_line();
      ic_mem_read  = (pat == 0 || pat == 3 || pat == 4);
      dc_mem_read  = (pat == 1 || pat == 3 || pat == 5);
      dc_mem_write = (pat == 2 || pat == 4 || pat == 5);
      serve($urandom_range(1, 4), rand_line(), 1'($urandom_range(0, 1)), 1'b0);
      if (ic_mem_read || dc_mem_read || dc_mem_write)
        serve($urandom_range(1, 4), rand_line(), 1'($urandom_range(0, 1)), 1'b0);
      chk_quiet("round_idle");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
